// File: rtl/dma_sample_unpacker_pkg.sv
// Shared widths and lane helpers for the DMA sample unpacker.
package dma_unpack_pkg;
  localparam int SAMPLE_W = 16;
  localparam int WORD_W   = 64;
  localparam int LANES    = 4;

  typedef logic [1:0] lane_t;

  function automatic logic [SAMPLE_W-1:0] lane_sel(input logic [WORD_W-1:0] word, input lane_t lane);
    return word[lane*SAMPLE_W +: SAMPLE_W];
  endfunction
endpackage

// File: rtl/dma_sample_unpacker_if.sv
// Word fetch handshake between the DMA controller user port and the unpacker.
interface dma_sample_unpacker_if;
  import dma_unpack_pkg::*;
  logic              request;
  logic [WORD_W-1:0] data;
  logic              data_ready;

  modport master (output request, input data, input data_ready);
  modport slave  (input request, output data, output data_ready);
endinterface

// File: rtl/dma_sample_unpacker_fifo.sv
// Single-clock word FIFO with first-word fall-through head and occupancy count.
module dma_word_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 64,
  localparam int AW   = $clog2(DEPTH),
  localparam int OW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic [OW-1:0] occ
);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr, rptr;

  assign head = mem[rptr];

  always_ff @(posedge clk)
    if (push) mem[wptr] <= wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      occ  <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   occ <= occ + OW'(1);
        2'b01:   occ <= occ - OW'(1);
        default: occ <= occ;
      endcase
    end
  end
endmodule

// File: rtl/dma_sample_unpacker.sv
// Fetches 64-bit words into a local FIFO and emits one 16-bit sample per divider tick.
// Optional saturating underrun counter: define DMA_UNPACK_UNDERRUN_CNT_EN.
module dma_sample_unpacker
  import dma_unpack_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int DIVIDER    = 1024,
  parameter int DIV_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  dma_sample_unpacker_if.master dma,
  output logic                  sample_valid,
  output logic [SAMPLE_W-1:0]   sample_data,
  output logic                  underrun
`ifdef DMA_UNPACK_UNDERRUN_CNT_EN
  ,output logic [15:0]          underrun_count
`endif
);
  localparam int OCC_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [OCC_W:0]   DEPTH_CMP = (OCC_W+1)'(FIFO_DEPTH);
  localparam logic [DIV_W-1:0] DIV_LOAD  = DIV_W'(DIVIDER - 1);

  logic [OCC_W-1:0]  occ;
  logic [WORD_W-1:0] head;
  logic [DIV_W-1:0]  div_cnt;
  lane_t             lane;
  logic              req_q, push, pop, tick, have_word;

  // Words already counted plus the one possibly in flight bound the FIFO fill.
  assign dma.request = !rst && enable &&
                       (({1'b0, occ} + (OCC_W+1)'(req_q)) < DEPTH_CMP);
  // A strobe without a preceding request (e.g. right after reset) is dropped.
  assign push      = dma.data_ready && req_q;
  assign tick      = enable && (div_cnt == '0);
  assign have_word = (occ != '0);
  assign pop       = tick && have_word && (lane == 2'd3);

  dma_word_fifo #(.DEPTH(FIFO_DEPTH), .W(WORD_W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (dma.data),
    .pop   (pop),
    .head  (head),
    .occ   (occ)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      req_q        <= 1'b0;
      div_cnt      <= DIV_LOAD;
      lane         <= '0;
      sample_valid <= 1'b0;
      sample_data  <= '0;
      underrun     <= 1'b0;
    end else begin
      req_q        <= dma.request;
      div_cnt      <= (!enable || tick) ? DIV_LOAD : div_cnt - DIV_W'(1);
      sample_valid <= 1'b0;
      underrun     <= 1'b0;
      if (tick) begin
        if (have_word) begin
          sample_data  <= lane_sel(head, lane);
          sample_valid <= 1'b1;
          lane         <= lane + 2'd1;
        end else begin
          underrun <= 1'b1;
        end
      end
    end
  end

`ifdef DMA_UNPACK_UNDERRUN_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)
      underrun_count <= '0;
    else if (tick && !have_word && underrun_count != 16'hFFFF)
      underrun_count <= underrun_count + 16'd1;
  end
`endif
endmodule
